// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART transmitter (8 data bits, optional parity, 1 or 2 stop bits)
//
// Serialises bytes LSB first onto tx_serial. A one-byte holding register lets
// the source queue the next byte while a frame is in flight, so consecutive
// frames run back to back with no idle-high gap on the line.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        asynchronous active-high reset
//   tx_data    byte to send, sampled when tx_valid && tx_ready
//   tx_valid   tx_data is valid
//   tx_ready   block can accept a byte this cycle (holding register empty)
//   tx_serial  registered serial line, idles high
//   tx_busy    a frame is in progress
//   tx_done    one-cycle pulse on the last cycle of the final stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int PARITY       = 0,  // 0 none, 1 odd, 2 even
  parameter int STOP_BITS    = 1   // 1 or 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      idx_reg, idx_next;       // data bit index, reused as stop bit index
  logic [7:0]      data_reg, data_next;     // byte of the frame in flight
  logic [7:0]      hold_reg, hold_next;
  logic            hold_full_reg, hold_full_next;
  logic            serial_reg, serial_next;

  logic accept;
  logic baud_last;
  logic parity_bit;

  assign accept     = tx_valid && !hold_full_reg;
  assign baud_last  = (cnt_reg == CNT_MAX);
  assign parity_bit = (PARITY == 2) ? ^data_reg : ~^data_reg;

  assign tx_ready  = ~hold_full_reg;
  assign tx_serial = serial_reg;
  assign tx_busy   = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      data_reg      <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      serial_reg    <= 1'b1;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      data_reg      <= data_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      serial_reg    <= serial_next;
    end
  end

  // tx_serial is registered, so every transition loads the level of the
  // bit being entered; it therefore changes on the same edge as the state.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    data_next      = data_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    serial_next    = serial_reg;
    tx_done        = 1'b0;

    // Any byte accepted while a frame is running (including on the edge
    // that ends STOP) waits in the holding register.
    if (accept && (state_reg != IDLE)) begin
      hold_next      = tx_data;
      hold_full_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (hold_full_reg) begin
          data_next      = hold_reg;
          hold_full_next = 1'b0;
          cnt_next       = '0;
          state_next     = START;
          serial_next    = 1'b0;
        end else if (accept) begin
          data_next   = tx_data;
          cnt_next    = '0;
          state_next  = START;
          serial_next = 1'b0;
        end
      end

      START: begin
        if (baud_last) begin
          cnt_next    = '0;
          idx_next    = '0;
          state_next  = DATA;
          serial_next = data_reg[0];
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      DATA: begin
        if (baud_last) begin
          cnt_next = '0;
          if (idx_reg == 3'd7) begin
            idx_next = '0;
            if (PARITY != 0) begin
              state_next  = PAR;
              serial_next = parity_bit;
            end else begin
              state_next  = STOP;
              serial_next = 1'b1;
            end
          end else begin
            idx_next    = idx_reg + 3'd1;
            serial_next = data_reg[idx_reg + 3'd1];
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      PAR: begin
        if (baud_last) begin
          cnt_next    = '0;
          idx_next    = '0;
          state_next  = STOP;
          serial_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      STOP: begin
        if (baud_last) begin
          cnt_next = '0;
          if (idx_reg == STOP_LAST) begin
            tx_done  = 1'b1;
            idx_next = '0;
            // Only a byte held before this edge chains straight into the
            // next start bit; one accepted on this edge stays in the hold.
            if (hold_full_reg) begin
              data_next      = hold_reg;
              hold_full_next = 1'b0;
              state_next     = START;
              serial_next    = 1'b0;
            end else begin
              state_next  = IDLE;
              serial_next = 1'b1;
            end
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      default: begin
        state_next  = IDLE;
        serial_next = 1'b1;
      end
    endcase
  end

endmodule
